// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master control unit and its serial clock generator.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } spi_state_t;

   // Mode 0: sclk idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int unsigned SPI_DATA_WIDTH = 16;
   localparam int unsigned SPI_CLK_DIV    = 4;

endpackage

// File: rtl/spi_sclk_gen.sv
// Serial clock generator: divides clk by 2*CLK_DIV while run is high and
// flags the clk edge on which sclk will rise or fall.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic sclk,
   output logic rise_next,
   output logic fall_next
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             sclk_q;
   logic             wrap;

   always_comb begin
      wrap      = run && (div_cnt == DIV_MAX);
      rise_next = wrap && !sclk_q;
      fall_next = wrap && sclk_q;
      sclk      = sclk_q;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         div_cnt <= '0;
         sclk_q  <= SPI_CPOL;
      end else if (run) begin
         if (wrap) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_cu.sv
// SPI master control unit (mode 0, MSB first): sequences load, shift and done
// strobes for the datapath and drives sclk / ss_n.
module spi_cu
   import spi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
   parameter int unsigned CLK_DIV    = SPI_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic busy,
   output logic done,
   output logic i_load,
   output logic i_en,
   output logic tbuf_mosi_oe,
   output logic sclk,
   output logic ss_n
);

   localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);

   spi_state_t       state_q;
   spi_state_t       state_d;
   logic [BIT_W-1:0] bit_cnt;
   logic             gen_run;
   logic             gen_clear;
   logic             rise_next;
   logic             fall_next;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk       (clk),
      .rst       (rst),
      .run       (gen_run),
      .clear     (gen_clear),
      .sclk      (sclk),
      .rise_next (rise_next),
      .fall_next (fall_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counts rising sclk edges; i_en marks exactly those edges.
   always_ff @(posedge clk) begin
      if (rst || (state_q == LOAD)) begin
         bit_cnt <= '0;
      end else if (i_en) begin
         bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      gen_run      = 1'b0;
      gen_clear    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      i_load       = 1'b0;
      i_en         = 1'b0;
      tbuf_mosi_oe = 1'b0;
      ss_n         = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            i_load    = 1'b1;
            busy      = 1'b1;
            ss_n      = 1'b0;
            gen_clear = 1'b1;
            state_d   = SHIFT;
         end
         SHIFT: begin
            busy         = 1'b1;
            ss_n         = 1'b0;
            tbuf_mosi_oe = 1'b1;
            gen_run      = 1'b1;
            i_en         = rise_next;
            if (fall_next && (bit_cnt == BIT_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done         = 1'b1;
            busy         = 1'b1;
            ss_n         = 1'b0;
            tbuf_mosi_oe = 1'b1;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_cu.sv
// Bench for spi_cu: two instances (16/4 and 8/2) compared every cycle against a
// phase-based timeline model, plus a small datapath/slave model for data checks.
module tb_spi_cu;

   localparam int DW_A  = 16;
   localparam int CD_A  = 4;
   localparam int DW_B  = 8;
   localparam int CD_B  = 2;
   localparam int LEN_A = 2 + 2 * DW_A * CD_A;
   localparam int LEN_B = 2 + 2 * DW_B * CD_B;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   logic busy_a, done_a, i_load_a, i_en_a, oe_a, sclk_a, ss_n_a;
   logic busy_b, done_b, i_load_b, i_en_b, oe_b, sclk_b, ss_n_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spi_cu #(
      .DATA_WIDTH (DW_A),
      .CLK_DIV    (CD_A)
   ) dut_a (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .busy         (busy_a),
      .done         (done_a),
      .i_load       (i_load_a),
      .i_en         (i_en_a),
      .tbuf_mosi_oe (oe_a),
      .sclk         (sclk_a),
      .ss_n         (ss_n_a)
   );

   spi_cu #(
      .DATA_WIDTH (DW_B),
      .CLK_DIV    (CD_B)
   ) dut_b (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .busy         (busy_b),
      .done         (done_b),
      .i_load       (i_load_b),
      .i_en         (i_en_b),
      .tbuf_mosi_oe (oe_b),
      .sclk         (sclk_b),
      .ss_n         (ss_n_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected {busy,done,i_load,i_en,oe,sclk,ss_n} for a cycle ph cycles after
   // the edge that accepted en (ph<0 means no transfer in progress).
   function automatic logic [6:0] expect_out(input int ph, input int dw, input int cd);
      int   span;
      logic busy_e, done_e, load_e, en_e, oe_e, sclk_e, ss_n_e;
      span = 2 * dw * cd;
      if (ph < 0) return 7'b0000001;
      busy_e = 1'b1;
      ss_n_e = 1'b0;
      load_e = (ph == 0);
      done_e = (ph == span + 1);
      oe_e   = (ph >= 1);
      sclk_e = (ph >= 1 && ph <= span) ? (((ph - 1) / cd) % 2 == 1) : 1'b0;
      en_e   = (ph >= 1 && ph <= span && ph % cd == 0 && (ph / cd) % 2 == 1);
      return {busy_e, done_e, load_e, en_e, oe_e, sclk_e, ss_n_e};
   endfunction

   int ph_a = -1;
   int ph_b = -1;

   always @(posedge clk) begin
      if (rst)                  ph_a <= -1;
      else if (ph_a < 0)        ph_a <= en ? 0 : -1;
      else if (ph_a == LEN_A-1) ph_a <= -1;
      else                      ph_a <= ph_a + 1;
   end

   always @(posedge clk) begin
      if (rst)                  ph_b <= -1;
      else if (ph_b < 0)        ph_b <= en ? 0 : -1;
      else if (ph_b == LEN_B-1) ph_b <= -1;
      else                      ph_b <= ph_b + 1;
   end

   logic        loop    = 1'b1;
   logic [15:0] tx_word = 16'h0;
   logic [15:0] sl_word = 16'h0;
   logic        loop_q  = 1'b1;
   logic [15:0] exp_word;
   logic [15:0] dp_reg;
   logic [15:0] sl_reg;
   logic        miso;
   int          en_cnt_a = 0;
   int          en_cnt_b = 0;

   assign miso = loop_q ? dp_reg[15] : sl_reg[15];

   always @(posedge clk) begin
      if (i_load_a) begin
         dp_reg   <= tx_word;
         sl_reg   <= sl_word;
         loop_q   <= loop;
         exp_word <= loop ? tx_word : sl_word;
         en_cnt_a <= 0;
      end else if (i_en_a) begin
         dp_reg   <= {dp_reg[14:0], miso};
         sl_reg   <= {sl_reg[14:0], 1'b0};
         en_cnt_a <= en_cnt_a + 1;
      end
      if (i_load_b)    en_cnt_b <= 0;
      else if (i_en_b) en_cnt_b <= en_cnt_b + 1;
   end

   logic chk_on = 1'b0;

   always @(negedge clk) begin
      if (chk_on) begin
         check("out_a", {25'b0, busy_a, done_a, i_load_a, i_en_a, oe_a, sclk_a, ss_n_a},
               {25'b0, expect_out(ph_a, DW_A, CD_A)});
         check("out_b", {25'b0, busy_b, done_b, i_load_b, i_en_b, oe_b, sclk_b, ss_n_b},
               {25'b0, expect_out(ph_b, DW_B, CD_B)});
         if (ph_a == LEN_A - 1) begin
            check("data_a", 32'(dp_reg), 32'(exp_word));
            check("ien_cnt_a", en_cnt_a, DW_A);
         end
         if (ph_b == LEN_B - 1) begin
            check("ien_cnt_b", en_cnt_b, DW_B);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      step(3);
      rst    = 1'b0;
      chk_on = 1'b1;
      step(50);

      en = 1'b1; step(1); en = 1'b0; step(140);

      loop = 1'b1; tx_word = 16'hA5C3;
      en = 1'b1; step(1); en = 1'b0; step(140);

      loop = 1'b0; tx_word = 16'h0F0F; sl_word = 16'h3C5A;
      en = 1'b1; step(1); en = 1'b0; step(140);

      loop = 1'b1; tx_word = 16'($urandom);
      en = 1'b1; step(300); en = 1'b0; step(140);

      // Reset lands while seven bits have been shifted.
      en = 1'b1; step(1); en = 1'b0; step(55);
      rst = 1'b1; step(1); rst = 1'b0; step(5);
      en = 1'b1; step(1); en = 1'b0; step(140);

      for (int i = 0; i < 20; i++) begin
         loop    = 1'($urandom_range(0, 1));
         tx_word = 16'($urandom);
         sl_word = 16'($urandom);
         en = 1'b1;
         step(int'($urandom_range(1, 3)));
         en = 1'b0;
         if ($urandom_range(0, 4) == 0) begin
            step(int'($urandom_range(1, 120)));
            rst = 1'b1; step(1); rst = 1'b0;
         end
         step(int'($urandom_range(0, 150)));
      end
      step(140);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_cu.md
Name: spi_cu

Overview:
Control unit for the SPI master datapath (spi_dp). It accepts a CPU start request and generates the serial clock and slave select. It drives the datapath strobes i_load, i_en and tbuf_mosi_oe, and raises done once a full word has been exchanged. It is SPI mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.

Parameters:
DATA_WIDTH, 16, bits per transfer; must equal the datapath width.
CLK_DIV, 4, clk cycles per sclk half-period; legal range is 2 or more.

Ports:
clk  input  1  system clock; one clock domain; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  start request; sampled only in IDLE.
busy  output  1  high from LOAD through DONE inclusive.
done  output  1  one-cycle pulse; datapath rx_buf loads on it.
i_load  output  1  datapath parallel-load strobe.
i_en  output  1  datapath shift-enable strobe.
tbuf_mosi_oe  output  1  mosi tristate enable.
sclk  output  1  SPI serial clock.
ss_n  output  1  active-low slave select.

Behaviour:
- Reset: rst=1 at a clk edge forces IDLE on that edge, including mid-transfer. Reset values: sclk=0, ss_n=1, busy=0, done=0, i_load=0, i_en=0, tbuf_mosi_oe=0. The divider counter and bit counter clear to 0.
- States: IDLE, LOAD, SHIFT, DONE. All outputs except i_en are registered or Moore-decoded from state and registers; i_en is the only combinational strobe.
- IDLE: ss_n=1, sclk=0, tbuf_mosi_oe=0. If en=1 at an edge, go to LOAD. If en=0, stay in IDLE.
- LOAD: lasts exactly one cycle. i_load=1, ss_n=0, busy=1. Next state is SHIFT; the divider counter and bit counter are cleared.
- SHIFT: ss_n=0, tbuf_mosi_oe=1.
  - The divider counter counts 0..CLK_DIV-1 and wraps; sclk toggles on the edge where the counter equals CLK_DIV-1.
  - i_en = (state==SHIFT) and (counter==CLK_DIV-1) and (sclk==0). The datapath therefore shifts miso in on the same edge that sclk rises.
  - The bit counter increments on each rising sclk.
  - When bit counter==DATA_WIDTH and sclk falls, go to DONE. sclk is 0 on exit.
- Exactly DATA_WIDTH i_en pulses occur per transfer; i_en is never asserted outside SHIFT.
- DONE: lasts exactly one cycle. done=1, ss_n=0, tbuf_mosi_oe=1, busy=1. Next state is IDLE, where ss_n goes to 1 and tbuf_mosi_oe goes to 0.
- Latency: let edge E0 sample en=1.
  - i_load is high in the cycle after E0.
  - The first sclk rise is at E0+1+CLK_DIV.
  - done is high in the cycle after edge E0+1+2·DATA_WIDTH·CLK_DIV. With defaults this is edge 129.
- en while busy=1 is ignored and not queued. If en is still high in the cycle after DONE, a new transfer starts from that IDLE cycle.
- Simultaneous rst and en: rst wins.
- Bit counter width is clog2(DATA_WIDTH+1). Divider width is clog2(CLK_DIV). Neither counter may overflow.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11;
  - SPI_CPOL=0 and SPI_CPHA=0 constants;
  - the default DATA_WIDTH and CLK_DIV values.
- One natural sub-module is spi_sclk_gen. It contains the divider counter and sclk toggle, with inputs run and clear, and outputs sclk, rise_next and fall_next. The top-level FSM uses rise_next to generate i_en.

Test Plan:
1. Reset then idle, with en=0 for 50 cycles -> ss_n=1, sclk=0, i_load=0, i_en=0, tbuf_mosi_oe=0, done=0, busy=0 throughout.
2. Single transfer with defaults: en pulsed for 1 cycle at E0 -> i_load high only in cycle E0+1; 16 sclk rising edges, the first at E0+5; exactly 16 i_en pulses, each coincident with a sclk rise; done high for one cycle after E0+129; ss_n low from E0+1 through DONE.
3. Loopback with the datapath (miso tied to mosi), CPU writing 16'hA5C3 -> after done, the datapath read returns 16'hA5C3; a bench slave model returning 16'h3C5A yields 16'h3C5A.
4. en held high for 300 cycles -> back-to-back transfers with exactly one IDLE cycle between a done pulse and the next i_load; no extra i_en pulses.
5. rst asserted while the bit counter is 7 in SHIFT -> on the next edge ss_n=1, sclk=0, busy=0, with no done pulse; a following en starts a clean 16-bit transfer.
6. CLK_DIV=2, DATA_WIDTH=8 instance -> done high after edge E0+33; sclk period is 4 clk cycles; exactly 8 i_en pulses.
